// File: rtl/cfa_window5x5_if.sv
// Pixel stream in, 5x5 window taps out, for the CFA window generator.
// The source drives start/pix_in/pix_valid; the window generator drives the rest.
interface cfa_window5x5_if #(
  parameter int PW    = 12,
  parameter int CNT_W = 12
);
  logic             start;
  logic [PW-1:0]    pix_in;
  logic             pix_valid;
  logic [PW-1:0]    e1t1, e1t2, e1t3, e1t4, e1t5;
  logic [PW-1:0]    e2t1, e2t2, e2t3, e2t4, e2t5;
  logic [PW-1:0]    e3t1, e3t2, e3t3, e3t4, e3t5;
  logic [PW-1:0]    e4t1, e4t2, e4t3, e4t4, e4t5;
  logic [PW-1:0]    e5t1, e5t2, e5t3, e5t4, e5t5;
  logic             win_valid;
  logic [CNT_W-1:0] ctr_row;
  logic [CNT_W-1:0] ctr_col;
  logic             frame_done;

  modport master (
    output start, pix_in, pix_valid,
    input  e1t1, e1t2, e1t3, e1t4, e1t5,
    input  e2t1, e2t2, e2t3, e2t4, e2t5,
    input  e3t1, e3t2, e3t3, e3t4, e3t5,
    input  e4t1, e4t2, e4t3, e4t4, e4t5,
    input  e5t1, e5t2, e5t3, e5t4, e5t5,
    input  win_valid, ctr_row, ctr_col, frame_done
  );

  modport slave (
    input  start, pix_in, pix_valid,
    output e1t1, e1t2, e1t3, e1t4, e1t5,
    output e2t1, e2t2, e2t3, e2t4, e2t5,
    output e3t1, e3t2, e3t3, e3t4, e3t5,
    output e4t1, e4t2, e4t3, e4t4, e4t5,
    output e5t1, e5t2, e5t3, e5t4, e5t5,
    output win_valid, ctr_row, ctr_col, frame_done
  );
endinterface

// File: rtl/cfa_window5x5.sv
// Raster-to-5x5-window generator: four line buffers feed a 5x5 tap register,
// and win_valid flags every fully-interior window (no border padding).
module cfa_window5x5 #(
  parameter int pixelBitWidth = 12,
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480,
  parameter int CNT_W         = 12
) (
  input  logic clk,
  input  logic rst,
  cfa_window5x5_if.slave win_if
);

  localparam int PW = pixelBitWidth;
  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] FILL_ROWS = CNT_W'(4);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] row_q, row_d, col_q, col_d;
  logic [CNT_W-1:0] ctr_row_q, ctr_row_d, ctr_col_q, ctr_col_d;
  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [PW-1:0]    taps_q [5][5];
  logic [PW-1:0]    taps_d [5][5];

  logic [PW-1:0]    lb_mem [4][IMG_WIDTH];
  logic [PW-1:0]    lb_rd  [4];
  logic [AW-1:0]    lb_addr;
  logic             accept, last_col;

  assign accept   = win_if.pix_valid && !win_if.start &&
                    ((state_q == FILL) || (state_q == STREAM));
  assign last_col = (col_q == LAST_COL);
  assign lb_addr  = col_q[AW-1:0];

  always_comb begin
    for (int k = 0; k < 4; k++) lb_rd[k] = lb_mem[k][lb_addr];
  end

  // NOTE: the line-buffer RAM has no reset; FILL overwrites every entry before
  // it can reach a valid window, and a reset would stop it mapping onto RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_mem[0][lb_addr] <= win_if.pix_in;
      lb_mem[1][lb_addr] <= lb_rd[0];
      lb_mem[2][lb_addr] <= lb_rd[1];
      lb_mem[3][lb_addr] <= lb_rd[2];
    end
  end

  // NOTE: every signal gets its default before any branch so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    ctr_row_d    = ctr_row_q;
    ctr_col_d    = ctr_col_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    taps_d       = taps_q;

    if (win_if.start) begin
      state_d = FILL;
      row_d   = '0;
      col_d   = '0;
    end else if (accept) begin
      col_d = last_col ? '0 : col_q + CNT_W'(1);
      row_d = last_col ? row_q + CNT_W'(1) : row_q;
      if (last_col && (state_q == FILL) && (row_q == FILL_ROWS - CNT_W'(1)))
        state_d = STREAM;
      if (last_col && (state_q == STREAM) && (row_q == LAST_ROW)) begin
        state_d      = DONE;
        frame_done_d = 1'b1;
      end

      // Columns 0..3 of a row only refill the taps, so no stale window escapes.
      if ((row_q >= FILL_ROWS) && (col_q >= CNT_W'(4))) begin
        win_valid_d = 1'b1;
        ctr_row_d   = row_q - CNT_W'(2);
        ctr_col_d   = col_q - CNT_W'(2);
      end

      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 4; c++)
          taps_d[r][c] = taps_q[r][c+1];
      taps_d[0][4] = lb_rd[3];
      taps_d[1][4] = lb_rd[2];
      taps_d[2][4] = lb_rd[1];
      taps_d[3][4] = lb_rd[0];
      taps_d[4][4] = win_if.pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      ctr_row_q    <= '0;
      ctr_col_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          taps_q[r][c] <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      ctr_row_q    <= ctr_row_d;
      ctr_col_q    <= ctr_col_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      taps_q       <= taps_d;
    end
  end

  assign win_if.win_valid  = win_valid_q;
  assign win_if.frame_done = frame_done_q;
  assign win_if.ctr_row    = ctr_row_q;
  assign win_if.ctr_col    = ctr_col_q;

  assign win_if.e1t1 = taps_q[0][0];
  assign win_if.e1t2 = taps_q[0][1];
  assign win_if.e1t3 = taps_q[0][2];
  assign win_if.e1t4 = taps_q[0][3];
  assign win_if.e1t5 = taps_q[0][4];
  assign win_if.e2t1 = taps_q[1][0];
  assign win_if.e2t2 = taps_q[1][1];
  assign win_if.e2t3 = taps_q[1][2];
  assign win_if.e2t4 = taps_q[1][3];
  assign win_if.e2t5 = taps_q[1][4];
  assign win_if.e3t1 = taps_q[2][0];
  assign win_if.e3t2 = taps_q[2][1];
  assign win_if.e3t3 = taps_q[2][2];
  assign win_if.e3t4 = taps_q[2][3];
  assign win_if.e3t5 = taps_q[2][4];
  assign win_if.e4t1 = taps_q[3][0];
  assign win_if.e4t2 = taps_q[3][1];
  assign win_if.e4t3 = taps_q[3][2];
  assign win_if.e4t4 = taps_q[3][3];
  assign win_if.e4t5 = taps_q[3][4];
  assign win_if.e5t1 = taps_q[4][0];
  assign win_if.e5t2 = taps_q[4][1];
  assign win_if.e5t3 = taps_q[4][2];
  assign win_if.e5t4 = taps_q[4][3];
  assign win_if.e5t5 = taps_q[4][4];

endmodule

// File: tb/tb_cfa_window5x5.sv
// Directed bench for cfa_window5x5 on an 8x6 frame with pixel = row*16+col (+ base).
// Outputs are sampled 1 time unit after each rising edge.
module tb_cfa_window5x5;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 12;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cfa_window5x5_if #(.PW(PW), .CNT_W(CW)) bus ();

  cfa_window5x5 #(
    .pixelBitWidth(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .win_if (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int win_count, done_count, first_win_at;

  logic [PW-1:0] tap [5][5];
  assign tap[0][0] = bus.e1t1; assign tap[0][1] = bus.e1t2; assign tap[0][2] = bus.e1t3;
  assign tap[0][3] = bus.e1t4; assign tap[0][4] = bus.e1t5;
  assign tap[1][0] = bus.e2t1; assign tap[1][1] = bus.e2t2; assign tap[1][2] = bus.e2t3;
  assign tap[1][3] = bus.e2t4; assign tap[1][4] = bus.e2t5;
  assign tap[2][0] = bus.e3t1; assign tap[2][1] = bus.e3t2; assign tap[2][2] = bus.e3t3;
  assign tap[2][3] = bus.e3t4; assign tap[2][4] = bus.e3t5;
  assign tap[3][0] = bus.e4t1; assign tap[3][1] = bus.e4t2; assign tap[3][2] = bus.e4t3;
  assign tap[3][3] = bus.e4t4; assign tap[3][4] = bus.e4t5;
  assign tap[4][0] = bus.e5t1; assign tap[4][1] = bus.e5t2; assign tap[4][2] = bus.e5t3;
  assign tap[4][3] = bus.e5t4; assign tap[4][4] = bus.e5t5;

  task automatic check(input bit ok, input string msg);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s", msg);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int base, input int r, input int c);
    return PW'(base + r * 16 + c);
  endfunction

  task automatic do_start();
    bus.start     = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_in    = 12'hABC;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    check(bus.win_valid === 1'b0,
          $sformatf("start_no_win: win_valid=%b expected 0", bus.win_valid));
  endtask

  // Feeds n_pix raster pixels from (r0,c0); checks win_valid, frame_done,
  // centre coordinates and all 25 taps against the raster pattern.
  task automatic feed_pixels(input int r0, input int c0, input int n_pix,
                             input bit toggle, input int base);
    int r, c, bad;
    bit exp_win, exp_done;
    r = r0; c = c0;
    win_count = 0; done_count = 0; first_win_at = 0;
    for (int k = 0; k < n_pix; k++) begin
      if (toggle) begin
        bus.pix_valid = 1'b0;
        bus.pix_in    = 12'hFFF;
        @(posedge clk); #1;
        check(bus.win_valid === 1'b0,
              $sformatf("stall_win (%0d,%0d): win_valid=%b expected 0", r, c, bus.win_valid));
      end
      bus.pix_valid = 1'b1;
      bus.pix_in    = pix(base, r, c);
      @(posedge clk); #1;
      exp_win  = (r >= 4) && (c >= 4);
      exp_done = (r == H - 1) && (c == W - 1);
      check(bus.win_valid === exp_win,
            $sformatf("win_valid (%0d,%0d): got %b expected %b", r, c, bus.win_valid, exp_win));
      check(bus.frame_done === exp_done,
            $sformatf("frame_done (%0d,%0d): got %b expected %b", r, c, bus.frame_done, exp_done));
      if (bus.frame_done === 1'b1) done_count++;
      if (exp_win) begin
        win_count++;
        if (first_win_at == 0) first_win_at = k + 1;
        check(bus.ctr_row === CW'(r - 2) && bus.ctr_col === CW'(c - 2),
              $sformatf("ctr (%0d,%0d): got (%0d,%0d) expected (%0d,%0d)",
                        r, c, bus.ctr_row, bus.ctr_col, r - 2, c - 2));
        bad = 0;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            if (tap[i][j] !== pix(base, r - 4 + i, c - 4 + j)) bad++;
        check(bad == 0,
              $sformatf("taps (%0d,%0d): %0d wrong, e1t1=%h e3t3=%h e5t5=%h expected %h %h %h",
                        r, c, bad, bus.e1t1, bus.e3t3, bus.e5t5, pix(base, r - 4, c - 4),
                        pix(base, r - 2, c - 2), pix(base, r, c)));
      end
      c++;
      if (c == W) begin c = 0; r++; end
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        if (tap[i][j] !== '0) bad++;
    check(bad == 0 && bus.win_valid === 1'b0 && bus.frame_done === 1'b0 &&
          bus.ctr_row === '0 && bus.ctr_col === '0,
          $sformatf("%s: nonzero taps=%0d win_valid=%b frame_done=%b ctr=(%0d,%0d) expected all 0",
                    name, bad, bus.win_valid, bus.frame_done, bus.ctr_row, bus.ctr_col));
  endtask

  task automatic check_frame_totals(input string name);
    check(first_win_at == 37,
          $sformatf("%s first_win: at pixel %0d expected 37", name, first_win_at));
    check(win_count == 8,
          $sformatf("%s win_count: got %0d expected 8", name, win_count));
    check(done_count == 1,
          $sformatf("%s done_count: got %0d expected 1", name, done_count));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.pix_valid = 1'b0; bus.pix_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_outputs_zero("reset_state");
    bus.pix_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check(bus.win_valid === 1'b0,
            $sformatf("idle_ignore: win_valid=%b expected 0", bus.win_valid));
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    do_start();
    feed_pixels(0, 0, W * H, 1'b0, 0);
    check_frame_totals("full_frame");
  endtask

  task automatic test_stall_toggle();
    do_start();
    feed_pixels(0, 0, W * H, 1'b1, 0);
    check_frame_totals("stall_toggle");
  endtask

  task automatic test_row_wrap_and_done();
    do_start();
    feed_pixels(0, 0, 5 * W, 1'b0, 0);
    check(bus.win_valid === 1'b1 && bus.e5t5 === 12'h047,
          $sformatf("wrap_last_win: win_valid=%b e5t5=%h expected 1 047", bus.win_valid, bus.e5t5));
    feed_pixels(5, 0, 4, 1'b0, 0);
    check(win_count == 0,
          $sformatf("wrap_no_win: got %0d windows expected 0", win_count));
    feed_pixels(5, 4, 1, 1'b0, 0);
    check(bus.win_valid === 1'b1 && bus.e1t1 === 12'h010 && bus.e5t5 === 12'h054 &&
          bus.ctr_row === CW'(3) && bus.ctr_col === CW'(2),
          $sformatf("wrap_first_win: v=%b e1t1=%h e5t5=%h ctr=(%0d,%0d) expected 1 010 054 (3,2)",
                    bus.win_valid, bus.e1t1, bus.e5t5, bus.ctr_row, bus.ctr_col));
    feed_pixels(5, 5, 3, 1'b0, 0);
    check(bus.frame_done === 1'b1 && bus.win_valid === 1'b1 && bus.e5t5 === 12'h057,
          $sformatf("done_pulse: frame_done=%b win_valid=%b e5t5=%h expected 1 1 057",
                    bus.frame_done, bus.win_valid, bus.e5t5));
    bus.pix_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.pix_in = PW'(12'h300 + k);
      @(posedge clk); #1;
      check(bus.win_valid === 1'b0 && bus.frame_done === 1'b0 && bus.ctr_row === CW'(3) &&
            bus.ctr_col === CW'(5) && bus.e5t5 === 12'h057,
            $sformatf("done_hold %0d: v=%b fd=%b ctr=(%0d,%0d) e5t5=%h expected 0 0 (3,5) 057",
                      k, bus.win_valid, bus.frame_done, bus.ctr_row, bus.ctr_col, bus.e5t5));
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic test_restart_mid_frame();
    do_start();
    feed_pixels(0, 0, 2 * W + 3, 1'b0, 12'h800);
    do_start();
    feed_pixels(0, 0, W * H, 1'b0, 0);
    check_frame_totals("restart");
  endtask

  task automatic test_async_reset();
    do_start();
    feed_pixels(0, 0, 4 * W + 6, 1'b0, 12'h400);
    check(bus.win_valid === 1'b1,
          $sformatf("pre_reset_win: win_valid=%b expected 1", bus.win_valid));
    #3 rst = 1'b1;
    #1 check_outputs_zero("async_reset");
    #2 rst = 1'b0;
    @(posedge clk); #1;
    bus.pix_valid = 1'b1;
    bus.pix_in    = 12'h123;
    repeat (6) begin
      @(posedge clk); #1;
      check(bus.win_valid === 1'b0 && bus.ctr_row === '0 && bus.ctr_col === '0,
            $sformatf("post_reset_ignore: v=%b ctr=(%0d,%0d) expected 0 (0,0)",
                      bus.win_valid, bus.ctr_row, bus.ctr_col));
    end
    bus.pix_valid = 1'b0;
    test_full_frame();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall_toggle();
    test_row_wrap_and_done();
    test_restart_mid_frame();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cfa_window5x5.md
Name: cfa_window5x5

Overview:
- Raster-to-window generator that feeds the 5x5 gradient/sum stages of the CFA pipeline.
- Accepts one Bayer pixel per cycle in raster order and keeps four line buffers plus a 5x5 tap register.
- Drives the 25 taps e1t1..e5t5 with a one-cycle win_valid qualifier for every fully-interior window. No border padding is applied.

Parameters:
- pixelBitWidth, 12, bits per pixel.
- IMG_WIDTH, 640, pixels per line (>=5).
- IMG_HEIGHT, 480, lines per frame (>=5).
- CNT_W, 12, counter/coordinate width (2^CNT_W > max(IMG_WIDTH, IMG_HEIGHT)).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  frame start pulse; clears counters and begins a new frame.
- pix_in  input  pixelBitWidth  raster pixel.
- pix_valid  input  1  pix_in accepted this cycle when high and state is FILL/STREAM.
- e1t1..e5t5  output  pixelBitWidth each (25 regs)  window taps; e<r>t<c>, r=1 top/oldest row, c=1 leftmost/oldest column.
- win_valid  output  1  taps hold a new complete window this cycle.
- ctr_row  output  CNT_W  image row of centre tap e3t3, valid with win_valid.
- ctr_col  output  CNT_W  image column of centre tap e3t3, valid with win_valid.
- frame_done  output  1  one-cycle pulse after the last pixel of the frame.

Behaviour:
- Reset (async, rst=1): state IDLE; row/col counters 0; all taps, ctr_row, ctr_col, win_valid and frame_done = 0. Line buffer RAM is not reset; FILL overwrites it before use.
- FSM states:
  - IDLE: pix_valid ignored; start -> FILL.
  - FILL: rows 0..3.
  - STREAM: rows 4..IMG_HEIGHT-1.
  - DONE: pix_valid ignored; start -> FILL.
- Transitions: FILL -> STREAM when pixel (3, IMG_WIDTH-1) is accepted. STREAM -> DONE when pixel (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.
- start in any state (including mid-frame in FILL/STREAM):
  - counters cleared, state -> FILL.
  - a pix_valid in the same cycle as start is ignored.
  - win_valid cannot assert until four new lines are filled.
- Acceptance: a pixel is accepted when pix_valid=1 in FILL/STREAM and start=0. Cycles with pix_valid=0 are stalls: counters, taps, line buffers and state all hold, and win_valid=0.
- Counters on acceptance: col increments; at IMG_WIDTH-1 col wraps to 0 and row increments.
- Line buffers: lb0..lb3, each IMG_WIDTH deep, read-before-write at address col. On acceptance at column c:
  - lb0[c]<=pix_in, lb1[c]<=old lb0[c], lb2[c]<=old lb1[c], lb3[c]<=old lb2[c].
  - taps shift one column left (e<r>t<k> <= e<r>t<k+1> for k=1..4).
  - new column: e1t5<=old lb3[c], e2t5<=old lb2[c], e3t5<=old lb1[c], e4t5<=old lb0[c], e5t5<=pix_in.
- win_valid is registered and asserts the cycle after acceptance of pixel (r,c) when r>=4 and c>=4. The window then covers rows r-4..r and columns c-4..c. ctr_row=r-2, ctr_col=c-2.
- Latency: one cycle from the accepting edge to taps/win_valid.
- Row wrap: columns 0..3 of each row refill the tap columns and produce no window, so stale left-row data is never flagged valid.
- Window count per frame: (IMG_HEIGHT-4)*(IMG_WIDTH-4).
- frame_done: 1 for exactly one cycle, coincident with the win_valid of the final window. It does not re-assert in DONE.
- Taps and ctr_* hold their last value when win_valid=0. Downstream samples only when win_valid=1.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Full frame, IMG_WIDTH=8, IMG_HEIGHT=6, pix=row*16+col, pix_valid continuous after start:
   - first win_valid the cycle after the 37th accepted pixel, with e1t1=0x00, e3t3=0x22, e5t5=0x44, ctr=(2,2).
   - exactly 8 win_valid pulses.
2. Same frame with pix_valid toggling 1/0:
   - identical 8 windows and tap values.
   - win_valid never asserts in the cycle following a stall cycle.
3. Row wrap:
   - after window at (4,7), i.e. e5t5=0x47, no win_valid during (5,0)..(5,3).
   - next window at (5,4): e1t1=0x10, e5t5=0x54, ctr=(3,2).
4. frame_done:
   - asserts together with the window at (5,7), e5t5=0x57.
   - 20 further pix_valid cycles in DONE produce no win_valid and no counter change.
5. start mid-frame at row 2, col 3, then a fresh frame:
   - no win_valid until the 37th accepted pixel of the new frame.
   - first window e1t1=0x00, e5t5=0x44 (no stale data).
6. rst asserted mid-STREAM, asynchronously between clock edges:
   - all outputs 0 immediately.
   - pix_valid ignored until start; then behaves as scenario 1.
